// File: rtl/window_line_buffer.sv
`timescale 1ns/1ps
// window_line_buffer
// Streams a square raster image and emits KxK sliding windows with a
// valid/ready handshake. K-1 line memories hold the previous rows; a KxK
// shift register holds the current window.
// Optional feature: define WINDOW_STRIDE2_EN to add stride2_i (stride-2 output).
module window_line_buffer #(
  parameter int unsigned DATA_RES       = 8,
  parameter int unsigned KERNEL_WIDTH   = 3,
  parameter int unsigned MAX_LINE_WIDTH = 32
) (
  input  logic                                          clk_i,
  input  logic                                          resetn_i,
  input  logic                                          frame_start_i,
  input  logic [$clog2(MAX_LINE_WIDTH)-1:0]             image_dimension,
  input  logic [DATA_RES-1:0]                           pixel_i,
  input  logic                                          data_valid_i,
  output logic                                          ready_o,
  output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_RES-1:0] window_o,
  output logic                                          window_valid_o,
  input  logic                                          window_ready_i,
`ifdef WINDOW_STRIDE2_EN
  input  logic                                          stride2_i,
`endif
  output logic                                          frame_done_o
);

  localparam int unsigned K  = KERNEL_WIDTH;
  localparam int unsigned DW = $clog2(MAX_LINE_WIDTH);
  // One extra bit so that N = MAX_LINE_WIDTH is representable.
  localparam int unsigned NW = DW + 1;
  localparam logic [NW-1:0] C_MAX_N = NW'(MAX_LINE_WIDTH);
  localparam logic [NW-1:0] C_KM1   = NW'(K - 1);

  // Latched frame configuration and raster position.
  logic [DW-1:0]       r_dim;
  logic [DW-1:0]       r_row;
  logic [DW-1:0]       r_col;
  logic                r_valid;
  logic                r_done;

  logic [DATA_RES-1:0] r_win [K][K];
  logic [DATA_RES-1:0] r_lm  [K-1][MAX_LINE_WIDTH];

  logic                w_ready;
  logic                w_accept;
  logic [NW-1:0]       w_n;
  logic [NW-1:0]       w_row;
  logic [NW-1:0]       w_col;
  logic [DW-1:0]       w_col_idx;
  logic                w_row_last;
  logic                w_col_last;
  logic                w_stride_ok;
  logic                w_qualify;
  logic [DW-1:0]       w_row_next;
  logic [DW-1:0]       w_col_next;
  logic [DATA_RES-1:0] w_newcol [K];
  logic [K*K*DATA_RES-1:0] w_window;

  function automatic logic [NW-1:0] f_decode(input logic [DW-1:0] d);
    return (d == '0) ? C_MAX_N : {1'b0, d};
  endfunction

  assign w_ready        = !r_valid || window_ready_i;
  assign w_accept       = data_valid_i && w_ready;
  assign ready_o        = w_ready;
  assign window_valid_o = r_valid;
  assign frame_done_o   = r_done;
  assign window_o       = w_window;

  // Position of the pixel offered this cycle; a coincident frame start
  // makes it pixel (0,0) of the new frame with the new dimension.
  always_comb begin
    w_n        = frame_start_i ? f_decode(image_dimension) : f_decode(r_dim);
    w_row      = frame_start_i ? '0 : {1'b0, r_row};
    w_col      = frame_start_i ? '0 : {1'b0, r_col};
    w_col_idx  = w_col[DW-1:0];
    w_row_last = (w_row == (w_n - NW'(1)));
    w_col_last = (w_col == (w_n - NW'(1)));
    w_qualify  = (w_row >= C_KM1) && (w_col >= C_KM1) && w_stride_ok;
  end

`ifdef WINDOW_STRIDE2_EN
  logic r_stride2;
  logic w_stride2;

  // Stride selection latched at frame start.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_stride2 <= 1'b0;
    end else if (frame_start_i) begin
      r_stride2 <= stride2_i;
    end
  end

  // Stride 2 keeps windows whose offsets from (K-1,K-1) are both even.
  always_comb begin
    w_stride2   = frame_start_i ? stride2_i : r_stride2;
    w_stride_ok = !w_stride2 ||
                  ((w_row[0] == C_KM1[0]) && (w_col[0] == C_KM1[0]));
  end
`else
  assign w_stride_ok = 1'b1;
`endif

  // Raster advance: column wraps at N-1 and bumps the row; row wraps at N-1.
  always_comb begin
    w_row_next = w_row[DW-1:0];
    w_col_next = w_col[DW-1:0] + DW'(1);
    if (w_col_last) begin
      w_col_next = '0;
      w_row_next = w_row_last ? '0 : (w_row[DW-1:0] + DW'(1));
    end
  end

  // Frame configuration and position counters.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_dim <= '0;
      r_row <= '0;
      r_col <= '0;
    end else begin
      if (frame_start_i) begin
        r_dim <= image_dimension;
      end
      if (w_accept) begin
        r_row <= w_row_next;
        r_col <= w_col_next;
      end else if (frame_start_i) begin
        r_row <= '0;
        r_col <= '0;
      end
    end
  end

  // Window-valid flag and end-of-frame pulse.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (frame_start_i) begin
        r_valid <= 1'b0;
      end else if (w_accept && w_qualify) begin
        r_valid <= 1'b1;
      end else if (window_ready_i) begin
        r_valid <= 1'b0;
      end
      r_done <= w_accept && w_row_last && w_col_last;
    end
  end

  // Line memories form a per-column chain: entry j holds row (row-1-j).
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lm[0][w_col_idx] <= pixel_i;
      for (int unsigned j = 1; j < K - 1; j++) begin
        r_lm[j][w_col_idx] <= r_lm[j-1][w_col_idx];
      end
    end
  end

  // Incoming column, oldest row at the top, live pixel at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      w_newcol[r] = '0;
    end
    for (int unsigned r = 0; r < K - 1; r++) begin
      w_newcol[r] = r_lm[K-2-r][w_col_idx];
    end
    w_newcol[K-1] = pixel_i;
  end

  // Window shift register: one column shifts in per accepted pixel.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K-1] <= w_newcol[r];
      end
    end
  end

  // Flatten row-major with the top-left pixel in the MSBs.
  always_comb begin
    w_window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        w_window[((K*K-1)-(r*K+c))*DATA_RES +: DATA_RES] = r_win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
`timescale 1ns/1ps
module tb_window_line_buffer;

  localparam int DR  = 8;
  localparam int K   = 3;
  localparam int MLW = 32;
  localparam int DW  = $clog2(MLW);
  localparam int WW  = K*K*DR;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          fs     = 1'b0;
  logic          dv     = 1'b0;
  logic          wr     = 1'b1;
  logic [DW-1:0] dim    = '0;
  logic [DR-1:0] pix    = '0;
  logic          rdy;
  logic          wv;
  logic          fd;
  logic [WW-1:0] win;
`ifdef WINDOW_STRIDE2_EN
  logic          s2     = 1'b0;
`endif

  window_line_buffer #(
    .DATA_RES      (DR),
    .KERNEL_WIDTH  (K),
    .MAX_LINE_WIDTH(MLW)
  ) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .frame_start_i  (fs),
    .image_dimension(dim),
    .pixel_i        (pix),
    .data_valid_i   (dv),
    .ready_o        (rdy),
    .window_o       (win),
    .window_valid_o (wv),
    .window_ready_i (wr),
`ifdef WINDOW_STRIDE2_EN
    .stride2_i      (s2),
`endif
    .frame_done_o   (fd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: image captured in a 2-D array, expected windows in a queue.
  logic [DR-1:0] img [MLW][MLW];
  int            m_n   = MLW;
  int            m_row = 0;
  int            m_col = 0;
  bit            m_s2  = 1'b0;
  bit            exp_done = 1'b0;
  logic [WW-1:0] q[$];

  int            cyc = 0;
  int            first_valid_cyc = -1;
  int            done_cyc = -1;
  int            done_count = 0;
  int            ready_low = 0;
  int            acc_cyc [256];
  logic [WW-1:0] win_log[$];
  bit            stall_req = 1'b0;

  function automatic logic [WW-1:0] model_window(input int r0, input int c0);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w = {w[WW-DR-1:0], img[r0+r][c0+c]};
    return w;
  endfunction

  function automatic logic [WW-1:0] w9(input int a, input int b, input int c,
                                       input int d, input int e, input int f,
                                       input int g, input int h, input int i);
    return {DR'(a), DR'(b), DR'(c), DR'(d), DR'(e), DR'(f), DR'(g), DR'(h), DR'(i)};
  endfunction

  function automatic logic [WW-1:0] get_log(input int i);
    if (i < win_log.size()) return win_log[i];
    return '0;
  endfunction

  // Single compare process: check outputs against the model, then advance it.
  always @(negedge clk) begin
    bit acc;
    cyc++;
    if (!resetn) begin
      q.delete();
      m_row = 0; m_col = 0; m_n = MLW; m_s2 = 1'b0; exp_done = 1'b0;
    end
    check_i("ready", int'(rdy), int'((q.size() == 0) || wr));
    check_i("valid", int'(wv), int'(q.size() != 0));
    if (q.size() != 0) check_w("window", win, q[0]);
    check_i("done", int'(fd), int'(exp_done));

    if (wv && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (fd) begin done_count++; done_cyc = cyc; end
    if (!rdy) ready_low++;
    if (wv && wr) win_log.push_back(win);

    if (resetn) begin
      acc = dv && ((q.size() == 0) || wr);
      exp_done = 1'b0;
      if (q.size() != 0 && wr) void'(q.pop_front());
      if (fs) begin
        q.delete();
        m_row = 0; m_col = 0;
        m_n = (dim == '0) ? MLW : int'(dim);
`ifdef WINDOW_STRIDE2_EN
        m_s2 = s2;
`endif
      end
      if (acc) begin
        acc_cyc[pix] = cyc;
        img[m_row][m_col] = pix;
        if (m_row >= K-1 && m_col >= K-1 &&
            (!m_s2 || (((m_row-(K-1)) % 2 == 0) && ((m_col-(K-1)) % 2 == 0))))
          q.push_back(model_window(m_row-K+1, m_col-K+1));
        if (m_row == m_n-1 && m_col == m_n-1) begin
          exp_done = 1'b1; m_row = 0; m_col = 0;
        end else if (m_col == m_n-1) begin
          m_col = 0; m_row++;
        end else begin
          m_col++;
        end
      end
    end
  end

  // Consumer back-pressure: hold window_ready_i low 5 cycles at the first window.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_req && wv && wr) begin
        wr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        wr = 1'b1;
        stall_req = 1'b0;
      end
    end
  end

  task automatic send(input logic [DR-1:0] p, input bit start, input logic [DW-1:0] d);
    bit ok;
    pix = p; dv = 1'b1; fs = start;
    if (start) dim = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = rdy;
      @(posedge clk); #1;
      fs = 1'b0;
      if (ok) break;
      if (i == 99) begin
        tests++; fails++;
        $display("FAIL send_timeout: pixel %0d not accepted within 100 cycles", p);
      end
    end
    dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    win_log.delete();
    first_valid_cyc = -1; done_cyc = -1; done_count = 0; ready_low = 0;
  endtask

  task automatic stream_4x4(input int base);
    send(DR'(base), 1'b1, DW'(4));
    for (int p = 1; p < 16; p++) send(DR'(base + p), 1'b0, '0);
    idle(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    @(negedge clk);
    check_w("rst_window", win, '0);
    check_i("rst_valid", int'(wv), 0);
    check_i("rst_ready", int'(rdy), 1);
    check_i("rst_done", int'(fd), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(2);

    // K=3, N=4, free-flowing consumer
    clear_logs();
    stream_4x4(0);
    check_i("n4_count", win_log.size(), 4);
    check_w("n4_w0", get_log(0), w9(0,1,2,4,5,6,8,9,10));
    check_w("n4_w1", get_log(1), w9(1,2,3,5,6,7,9,10,11));
    check_w("n4_w2", get_log(2), w9(4,5,6,8,9,10,12,13,14));
    check_w("n4_w3", get_log(3), w9(5,6,7,9,10,11,13,14,15));
    check_i("n4_latency", first_valid_cyc, acc_cyc[10] + 1);
    check_i("n4_done_cyc", done_cyc, acc_cyc[15] + 1);
    check_i("n4_done_cnt", done_count, 1);

    // Same stream with a 5-cycle stall at the first window
    clear_logs();
    stall_req = 1'b1;
    stream_4x4(0);
    check_i("stall_ready_low", ready_low, 5);
    check_i("stall_count", win_log.size(), 4);
    check_w("stall_w0", get_log(0), w9(0,1,2,4,5,6,8,9,10));
    check_w("stall_w1", get_log(1), w9(1,2,3,5,6,7,9,10,11));
    check_w("stall_w3", get_log(3), w9(5,6,7,9,10,11,13,14,15));
    check_i("stall_done_cnt", done_count, 1);

    // N=2 < K: no windows, one done pulse
    clear_logs();
    send(DR'(0), 1'b1, DW'(2));
    for (int p = 1; p < 4; p++) send(DR'(p), 1'b0, '0);
    idle(4);
    check_i("n2_count", win_log.size(), 0);
    check_i("n2_done_cnt", done_count, 1);
    check_i("n2_done_cyc", done_cyc, acc_cyc[3] + 1);

    // Reset after pixel 9, then a fresh frame 100..115
    clear_logs();
    send(DR'(0), 1'b1, DW'(4));
    for (int p = 1; p < 10; p++) send(DR'(p), 1'b0, '0);
    resetn = 1'b0;
    @(negedge clk);
    check_i("mid_rst_valid", int'(wv), 0);
    check_w("mid_rst_window", win, '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
    clear_logs();
    stream_4x4(100);
    check_i("rst_frame_count", win_log.size(), 4);
    check_w("rst_frame_w0", get_log(0), w9(100,101,102,104,105,106,108,109,110));
    check_w("rst_frame_w3", get_log(3), w9(105,106,107,109,110,111,113,114,115));
    check_i("rst_frame_done", done_count, 1);

    // Frame restart mid-frame with N 4->5; later dimension change ignored
    clear_logs();
    send(DR'(0), 1'b1, DW'(4));
    for (int p = 1; p < 7; p++) send(DR'(p), 1'b0, '0);
    send(DR'(200), 1'b1, DW'(5));
    for (int p = 201; p < 225; p++) begin
      if (p == 210) dim = DW'(7);
      send(DR'(p), 1'b0, '0);
    end
    idle(4);
    check_i("restart_count", win_log.size(), 9);
    check_w("restart_w0", get_log(0), w9(200,201,202,205,206,207,210,211,212));
    check_w("restart_w8", get_log(8), w9(212,213,214,217,218,219,222,223,224));
    check_i("restart_done_cnt", done_count, 1);
    check_i("restart_done_cyc", done_cyc, acc_cyc[224] + 1);

    // Dimension 0 selects the maximum line width (32x32)
    clear_logs();
    for (int i = 0; i < MLW*MLW; i++) send(DR'(i), (i == 0), '0);
    idle(4);
    check_i("max_count", win_log.size(), (MLW-K+1)*(MLW-K+1));
    check_w("max_w0", get_log(0), w9(0,1,2,32,33,34,64,65,66));
    check_w("max_wlast", get_log(899), w9(189,190,191,221,222,223,253,254,255));
    check_i("max_done_cnt", done_count, 1);

`ifdef WINDOW_STRIDE2_EN
    // Stride 2, N=5: windows at top-left pixels 0, 2, 10, 12
    clear_logs();
    s2 = 1'b1;
    send(DR'(0), 1'b1, DW'(5));
    s2 = 1'b0;
    for (int p = 1; p < 25; p++) send(DR'(p), 1'b0, '0);
    idle(4);
    check_i("s2_count", win_log.size(), 4);
    check_w("s2_w0", get_log(0), w9(0,1,2,5,6,7,10,11,12));
    check_w("s2_w1", get_log(1), w9(2,3,4,7,8,9,12,13,14));
    check_w("s2_w2", get_log(2), w9(10,11,12,15,16,17,20,21,22));
    check_w("s2_w3", get_log(3), w9(12,13,14,17,18,19,22,23,24));
    check_i("s2_done_cnt", done_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
